// File: rtl/vend_pkg.sv
// Shared vending-machine types: amount width, state encodings and amount arithmetic.
package vend_pkg;

  localparam int unsigned AMT_W   = 8;
  localparam int unsigned MAX_AMT = 255;
  localparam int unsigned ST_W    = 3;

  typedef logic [AMT_W-1:0] amt_t;

  typedef enum logic [ST_W-1:0] {
    FS_IDLE    = 3'd0,
    FS_COLLECT = 3'd1,
    FS_CHANGE  = 3'd2,
    FS_ISSUE   = 3'd3
  } fare_state_e;

  typedef enum logic [ST_W-1:0] {
    TX_IDLE      = 3'd0,
    TX_SEND_RDY  = 3'd1,
    TX_SEND_DATA = 3'd2,
    TX_WAIT_CHG  = 3'd3
  } tx_state_e;

  // Carry-preserving sum so overflow past MAX_AMT is visible.
  function automatic logic [AMT_W:0] amt_sum(input amt_t a, input amt_t b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/chg_link_tx.sv
// Ready/data handshake into the change block, then waits for its completion.
// FARE_CHG_TIMEOUT_EN adds a bounded wait that reports a timeout.
module chg_link_tx
  import vend_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_c,
  input  logic [AMT_W-1:0] chg_amt,
  input  logic             chg_done,
  output logic             out_rdy,
  output logic [AMT_W-1:0] data_out,
  output logic             done_c,
  output logic             timeout_c
);

  tx_state_e  state_q, state_d;
  logic       out_rdy_q, out_rdy_d;
  amt_t       data_q, data_d;

`ifdef FARE_CHG_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    done_c    = 1'b0;
    timeout_c = 1'b0;
`ifdef FARE_CHG_TIMEOUT_EN
    cnt_d     = '0;
`endif
    case (state_q)
      TX_IDLE:      if (start_c) state_d = TX_SEND_RDY;
      TX_SEND_RDY:  state_d = TX_SEND_DATA;
      TX_SEND_DATA: state_d = TX_WAIT_CHG;
      TX_WAIT_CHG: begin
        if (chg_done) begin
          done_c  = 1'b1;
          state_d = TX_IDLE;
        end
`ifdef FARE_CHG_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          state_d   = TX_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = TX_IDLE;
    endcase
    // Outputs follow the next state so they line up with it once registered.
    out_rdy_d = (state_d == TX_SEND_RDY);
    data_d    = (state_d == TX_SEND_DATA) ? chg_amt : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TX_IDLE;
      out_rdy_q <= 1'b0;
      data_q    <= '0;
`ifdef FARE_CHG_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      out_rdy_q <= out_rdy_d;
      data_q    <= data_d;
`ifdef FARE_CHG_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign out_rdy  = out_rdy_q;
  assign data_out = data_q;

endmodule

// File: rtl/fare_collect.sv
// Ticket vending payment front end: price latch, coin accumulation, issue/change/refund.
// FARE_CHG_TIMEOUT_EN enables the change-completion timeout and the fault output.
module fare_collect
  import vend_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             price_RDY,
  input  logic [AMT_W-1:0] price,
  input  logic             coin_valid,
  input  logic [AMT_W-1:0] coin_value,
  input  logic             cancel,
  input  logic             chg_done,
  output logic             out_RDY,
  output logic [AMT_W-1:0] DATA_out,
  output logic             ticket,
  output logic             coin_reject,
  output logic [AMT_W-1:0] paid_amt,
  output logic             busy
`ifdef FARE_CHG_TIMEOUT_EN
  ,
  output logic             fault
`endif
);

  fare_state_e      state_q, state_d;
  amt_t             price_q, price_d;
  amt_t             paid_q, paid_d;
  amt_t             chg_q, chg_d;
  logic             refund_q, refund_d;
  logic             ticket_q, ticket_d;
  logic             coin_reject_q, coin_reject_d;
  logic             busy_q, busy_d;
  logic             start_c, coin_ok_c;
  logic             link_done_c, link_timeout_c;
  logic [AMT_W:0]   coin_sum_c;

  assign coin_sum_c = amt_sum(paid_q, coin_value);

  always_comb begin
    state_d   = state_q;
    price_d   = price_q;
    paid_d    = paid_q;
    chg_d     = chg_q;
    refund_d  = refund_q;
    start_c   = 1'b0;
    coin_ok_c = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (price_RDY && (price != '0)) begin
          state_d  = FS_COLLECT;
          price_d  = price;
          paid_d   = '0;
          chg_d    = '0;
          refund_d = 1'b0;
        end
      end
      FS_COLLECT: begin
        // Cancel wins over both the decision and a same-cycle coin.
        if (cancel) begin
          if (paid_q == '0) begin
            state_d = FS_IDLE;
          end else begin
            refund_d = 1'b1;
            chg_d    = paid_q;
            start_c  = 1'b1;
            state_d  = FS_CHANGE;
          end
        end else if (paid_q == price_q) begin
          state_d = FS_ISSUE;
        end else if (paid_q > price_q) begin
          chg_d   = paid_q - price_q;
          start_c = 1'b1;
          state_d = FS_CHANGE;
        end else if (coin_valid && (coin_sum_c <= (AMT_W + 1)'(MAX_AMT))) begin
          coin_ok_c = 1'b1;
          paid_d    = coin_sum_c[AMT_W-1:0];
        end
      end
      FS_CHANGE: begin
        if (link_done_c) begin
          state_d = refund_q ? FS_IDLE : FS_ISSUE;
        end else if (link_timeout_c) begin
          state_d = FS_IDLE;
        end
      end
      FS_ISSUE: begin
        state_d  = FS_IDLE;
        paid_d   = '0;
        chg_d    = '0;
        refund_d = 1'b0;
      end
      default: state_d = FS_IDLE;
    endcase
    ticket_d      = (state_d == FS_ISSUE);
    busy_d        = (state_d != FS_IDLE);
    coin_reject_d = coin_valid && !coin_ok_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FS_IDLE;
      price_q       <= '0;
      paid_q        <= '0;
      chg_q         <= '0;
      refund_q      <= 1'b0;
      ticket_q      <= 1'b0;
      coin_reject_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      price_q       <= price_d;
      paid_q        <= paid_d;
      chg_q         <= chg_d;
      refund_q      <= refund_d;
      ticket_q      <= ticket_d;
      coin_reject_q <= coin_reject_d;
      busy_q        <= busy_d;
    end
  end

  chg_link_tx #(
    .TIMEOUT (TIMEOUT)
  ) u_chg_link_tx (
    .clk       (clk),
    .rst       (rst),
    .start_c   (start_c),
    .chg_amt   (chg_q),
    .chg_done  (chg_done),
    .out_rdy   (out_RDY),
    .data_out  (DATA_out),
    .done_c    (link_done_c),
    .timeout_c (link_timeout_c)
  );

`ifdef FARE_CHG_TIMEOUT_EN
  logic fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= link_timeout_c;
  end

  assign fault = fault_q;
`else
  logic unused_timeout;
  assign unused_timeout = link_timeout_c;
`endif

  assign ticket      = ticket_q;
  assign coin_reject = coin_reject_q;
  assign paid_amt    = paid_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_fare_collect.sv
// Directed plus randomized bench for fare_collect against a transaction-level payment model.
module tb_fare_collect;

  localparam int unsigned TO = 8;
`ifdef FARE_CHG_TIMEOUT_EN
  localparam int LONG_DLY = TO - 1;
`else
  localparam int LONG_DLY = 10;
`endif

  logic       clk = 1'b0;
  logic       rst, price_RDY, coin_valid, cancel, chg_done;
  logic [7:0] price, coin_value, DATA_out, paid_amt;
  logic       out_RDY, ticket, coin_reject, busy;
`ifdef FARE_CHG_TIMEOUT_EN
  logic       fault;
`endif

  int errors = 0;
  int checks = 0;
  int m_paid = 0;

  fare_collect #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .price_RDY   (price_RDY),
    .price       (price),
    .coin_valid  (coin_valid),
    .coin_value  (coin_value),
    .cancel      (cancel),
    .chg_done    (chg_done),
    .out_RDY     (out_RDY),
    .DATA_out    (DATA_out),
    .ticket      (ticket),
    .coin_reject (coin_reject),
    .paid_amt    (paid_amt),
    .busy        (busy)
`ifdef FARE_CHG_TIMEOUT_EN
    ,
    .fault       (fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input int p);
    price_RDY = 1'b1;
    price     = 8'(p);
    tick();
    price_RDY = 1'b0;
    m_paid    = 0;
    chk("start_busy", 32'(busy), 1);
    chk("start_paid", 32'(paid_amt), 0);
  endtask

  // Model: a coin fits if the running total stays within 255.
  task automatic drive_coin(input int v);
    bit ok;
    ok         = (m_paid + v) <= 255;
    coin_valid = 1'b1;
    coin_value = 8'(v);
    tick();
    coin_valid = 1'b0;
    if (ok) m_paid += v;
    chk("coin_reject", 32'(coin_reject), ok ? 0 : 1);
    chk("paid_amt", 32'(paid_amt), m_paid);
  endtask

  // Called once the out_RDY edge has been ticked.
  task automatic change_seq(input int amt, input bit refund, input int dly);
    chk("rdy_pulse", 32'(out_RDY), 1);
    chk("rdy_data0", 32'(DATA_out), 0);
    tick();
    chk("rdy_drop", 32'(out_RDY), 0);
    chk("data_chg", 32'(DATA_out), amt);
    tick();
    chk("data_zero", 32'(DATA_out), 0);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("wait_ticket", 32'(ticket), 0);
      chk("wait_busy", 32'(busy), 1);
    end
    chg_done = 1'b1;
    tick();
    chg_done = 1'b0;
    chk("done_ticket", 32'(ticket), refund ? 0 : 1);
    chk("done_busy", 32'(busy), refund ? 0 : 1);
    if (!refund) begin
      tick();
      chk("ticket_end", 32'(ticket), 0);
      chk("busy_end", 32'(busy), 0);
    end
  endtask

  initial begin
    int p, v, iter;
    bit done, with_coin;

    rst = 1'b1; price_RDY = 1'b0; price = '0; coin_valid = 1'b0;
    coin_value = '0; cancel = 1'b0; chg_done = 1'b0;
    #2;
    chk("rst_out_RDY", 32'(out_RDY), 0);
    chk("rst_DATA_out", 32'(DATA_out), 0);
    chk("rst_ticket", 32'(ticket), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_paid", 32'(paid_amt), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Zero price ignored; coin while idle refused.
    price_RDY = 1'b1; price = 8'd0;
    tick();
    price_RDY = 1'b0;
    chk("zero_price_busy", 32'(busy), 0);
    coin_valid = 1'b1; coin_value = 8'd20;
    tick();
    coin_valid = 1'b0;
    chk("idle_coin_reject", 32'(coin_reject), 1);
    chk("idle_coin_paid", 32'(paid_amt), 0);
    tick();
    chk("reject_one_cycle", 32'(coin_reject), 0);

    // Overpay 180 with 100+100: change 20.
    start_txn(180);
    drive_coin(100);
    drive_coin(100);
    chk("over_paid200", 32'(paid_amt), 200);
    tick();
    change_seq(20, 1'b0, LONG_DLY);

    // Exact payment: ticket on the third cycle counting the coin cycle.
    start_txn(50);
    drive_coin(50);
    chk("exact_no_ticket_yet", 32'(ticket), 0);
    tick();
    chk("exact_ticket", 32'(ticket), 1);
    chk("exact_no_rdy", 32'(out_RDY), 0);
    tick();
    chk("exact_ticket_end", 32'(ticket), 0);
    chk("exact_no_rdy2", 32'(out_RDY), 0);

    // Overflowing coin refused; price_RDY ignored mid-collect; cancel refunds 200.
    start_txn(250);
    drive_coin(200);
    drive_coin(100);
    chk("ovf_busy", 32'(busy), 1);
    price_RDY = 1'b1; price = 8'd5;
    tick();
    price_RDY = 1'b0;
    tick();
    chk("reprice_ignored_rdy", 32'(out_RDY), 0);
    chk("reprice_ignored_paid", 32'(paid_amt), 200);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    change_seq(200, 1'b1, 2);

    // Cancel with partial payment 60.
    start_txn(100);
    drive_coin(60);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    change_seq(60, 1'b1, 3);
    chk("refund_no_ticket", 32'(ticket), 0);

    // Reset while waiting for change completion.
    start_txn(10);
    drive_coin(30);
    tick();
    tick();
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_paid", 32'(paid_amt), 0);
    chk("mid_rst_rdy", 32'(out_RDY), 0);
    chk("mid_rst_data", 32'(DATA_out), 0);
    chk("mid_rst_ticket", 32'(ticket), 0);
    #2 rst = 1'b0;
    chg_done = 1'b1;
    tick();
    chg_done = 1'b0;
    chk("post_rst_ticket", 32'(ticket), 0);
    chk("post_rst_busy", 32'(busy), 0);
    tick();
    chk("post_rst_ticket2", 32'(ticket), 0);

`ifdef FARE_CHG_TIMEOUT_EN
    // Withheld completion: fault after TO cycles in the wait.
    start_txn(30);
    drive_coin(50);
    tick();
    chk("to_rdy", 32'(out_RDY), 1);
    tick();
    tick();
    for (int k = 1; k <= int'(TO); k++) begin
      tick();
      chk("to_fault", 32'(fault), (k == int'(TO)) ? 1 : 0);
      chk("to_busy", 32'(busy), (k == int'(TO)) ? 0 : 1);
      chk("to_ticket", 32'(ticket), 0);
    end
    tick();
    chk("to_fault_end", 32'(fault), 0);
    chk("to_ticket_end", 32'(ticket), 0);
`endif

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      p = int'($urandom_range(1, 255));
      start_txn(p);
      done = 1'b0;
      iter = 0;
      while (!done) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          chk("gap_paid", 32'(paid_amt), m_paid);
          chk("gap_busy", 32'(busy), 1);
        end
        if (($urandom_range(0, 9) == 0) || (iter >= 40)) begin
          with_coin  = 1'($urandom_range(0, 1));
          cancel     = 1'b1;
          coin_valid = with_coin;
          coin_value = 8'($urandom_range(1, 255));
          tick();
          cancel     = 1'b0;
          coin_valid = 1'b0;
          chk("cancel_coin_reject", 32'(coin_reject), with_coin ? 1 : 0);
          chk("cancel_paid", 32'(paid_amt), m_paid);
          if (m_paid == 0) begin
            chk("cancel_empty_busy", 32'(busy), 0);
            chk("cancel_empty_rdy", 32'(out_RDY), 0);
          end else begin
            change_seq(m_paid, 1'b1, int'($urandom_range(0, 5)));
          end
          done = 1'b1;
        end else begin
          v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(150, 255))
                                          : int'($urandom_range(1, 100));
          drive_coin(v);
          if (m_paid >= p) begin
            tick();
            if (m_paid == p) begin
              chk("rnd_ticket", 32'(ticket), 1);
              chk("rnd_no_rdy", 32'(out_RDY), 0);
              tick();
              chk("rnd_ticket_end", 32'(ticket), 0);
              chk("rnd_busy_end", 32'(busy), 0);
            end else begin
              change_seq(m_paid - p, 1'b0, int'($urandom_range(0, 5)));
            end
            done = 1'b1;
          end
        end
        iter++;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fare_collect.md
# fare_collect

Payment-side front end of the ticket vending machine. It latches a ticket price, accumulates inserted coins, and decides the outcome: issue, issue with change, or refund on cancel. When change or a refund is owed, it drives the ready/data handshake into the `change` block. It then waits for that block's completion before issuing the ticket or returning to idle.

## Interface
Parameters:
- `TIMEOUT`, default 64: cycles allowed for `chg_done` before a fault; used only with `FARE_CHG_TIMEOUT_EN`.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `price_RDY` input 1: one-cycle pulse; `price` is valid in the same cycle.
- `price` input 8: ticket price, unsigned.
- `coin_valid` input 1: one-cycle pulse per inserted coin.
- `coin_value` input 8: coin amount, valid with `coin_valid`.
- `cancel` input 1: user abort, level-sampled.
- `chg_done` input 1: completion from the change block (its `state_cmp7`).
- `out_RDY` output 1: handshake ready to the change block (its `in_RDY7`).
- `DATA_out` output 8: change amount to the change block (its `DATA_in7`).
- `ticket` output 1: one-cycle issue pulse.
- `coin_reject` output 1: one-cycle pulse; the coin in the previous cycle was refused.
- `paid_amt` output 8: running total, for the display.
- `busy` output 1: high in every state except IDLE.
- `fault` output 1: one-cycle timeout pulse; present only with `FARE_CHG_TIMEOUT_EN`.

## Operation
States:
- IDLE → COLLECT on `price_RDY` with `price != 0`. `price` is latched and `paid` is cleared. `price_RDY` with `price == 0` is ignored.
- COLLECT:
  - Coin accepted: `paid <= paid + coin_value` when the 9-bit sum is ≤ 255. Otherwise `coin_reject` pulses and `paid` is unchanged.
  - Comparison uses the registered `paid`.
  - `paid == price` → ISSUE.
  - `paid > price` → SEND_RDY, with `chg = paid - price` (8-bit, no underflow possible).
- Cancel in COLLECT:
  - Has priority over the comparison and over a coin in the same cycle; that coin is rejected.
  - `paid == 0` → IDLE.
  - Otherwise `refund` flag set, `chg = paid` → SEND_RDY.
- SEND_RDY: `out_RDY=1`, `DATA_out=0`, one cycle → SEND_DATA.
- SEND_DATA: `out_RDY=0`, `DATA_out=chg`, one cycle → WAIT_CHG.
- WAIT_CHG: `DATA_out=0`. Sampling `chg_done=1` → ISSUE if `!refund`, else IDLE.
- ISSUE: `ticket=1` for one cycle → IDLE. Clears `paid`, `refund` and `chg`.
- Coins outside COLLECT: rejected, with `coin_reject` pulsing.
- `price_RDY` outside IDLE: ignored.
- `cancel` outside COLLECT: ignored.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - `out_RDY`, `DATA_out`, `ticket`, `coin_reject`, `busy`, `fault` and `paid_amt` all go to 0.
  - Any in-flight transaction is dropped with no ticket and no refund.
- All outputs are registered.
- Coin to `paid_amt` update: 1 cycle.
- Coin to `ticket` on an exact payment: 3 cycles (accept, compare/ISSUE entry, pulse).
- Overpay: the `out_RDY` pulse is followed by exactly one cycle of `DATA_out=chg`, then `DATA_out` returns to 0.
- After `chg_done`, `ticket` is high on the next cycle.
- `chg_done` already high at WAIT_CHG entry is accepted on the first WAIT_CHG cycle.

## Configuration
- `FARE_CHG_TIMEOUT_EN` defined:
  - A counter runs in WAIT_CHG.
  - If `TIMEOUT` cycles elapse without `chg_done`, `fault` pulses and the state goes to IDLE with no ticket.
- `FARE_CHG_TIMEOUT_EN` undefined: no `fault` port and no counter; WAIT_CHG waits indefinitely.

## Structure
- Shared `vend_pkg` (header) holds:
  - state encodings (3-bit),
  - `AMT_W=8`,
  - `MAX_AMT=255`.
- One sub-module, `chg_link_tx`, owns the SEND_RDY/SEND_DATA/WAIT_CHG handshake sequencing and the optional timeout counter. The top-level FSM hands it `chg` with a start pulse and receives `done` or `timeout` back.

## Test plan
- Price 180; coins 100, 100 → `paid_amt` 200; one `out_RDY` pulse, next cycle `DATA_out=20`, then 0; `chg_done` after 10 cycles → `ticket` pulse on the next cycle.
- Price 50; coin 50 → `ticket` 3 cycles after the coin; `out_RDY` never asserted.
- Price 250; coins 200, 100 → second coin gets `coin_reject`, `paid_amt` stays 200, state stays COLLECT.
- Price 100; coin 60; `cancel` → `out_RDY`, then `DATA_out=60`; after `chg_done` → IDLE, no `ticket`, `busy=0`.
- `rst` asserted mid-WAIT_CHG → all outputs 0 immediately; a later `chg_done` produces no `ticket`.
- With `FARE_CHG_TIMEOUT_EN`, `TIMEOUT=8`: withhold `chg_done` → `fault` pulse 8 cycles into WAIT_CHG, no `ticket`, back in IDLE.
